// File: rtl/add_round_key_if.sv
// Handshake and key-write bundle for add_round_key.
// master drives state words and key writes; slave is the add_round_key stage.
interface add_round_key_if #(
  parameter int AW = 6
) ();
  logic          key_wr_en;
  logic [AW-1:0] key_wr_addr;
  logic [31:0]   key_wr_data;
  logic          key_ready;
  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic [127:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic [3:0]    out_round;
  logic          out_last;

  modport master (
    output key_wr_en, key_wr_addr, key_wr_data,
    output in_valid, in_first, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, out_round, out_last
  );

  modport slave (
    input  key_wr_en, key_wr_addr, key_wr_data,
    input  in_valid, in_first, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, out_round, out_last
  );
endinterface

// File: rtl/add_round_key.sv
// AES AddRoundKey stage with internal expanded-key store and per-block round tracking.
// Optional sticky protocol checker (proto_err port) enabled by defining ARK_PROTO_CHECK_EN.
module add_round_key #(
  parameter int NR = 10,
  parameter int AW = 6
) (
  input  logic clk,
  input  logic rst,
  add_round_key_if.slave bus
`ifdef ARK_PROTO_CHECK_EN
  ,
  output logic proto_err
`endif
);

  localparam int unsigned   WORDS     = 4 * (NR + 1);
  localparam logic [3:0]    LAST_RND  = 4'(NR);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  logic [31:0]   key_mem [WORDS];
  logic          key_ready;
  logic          out_valid;
  logic [127:0]  out_data;
  logic [3:0]    out_round;
  logic          out_last;
  logic [3:0]    rnd;
  logic [3:0]    er;
  logic [AW-1:0] base;
  logic [127:0]  rk;
  logic          in_ready;
  logic          accept;
  logic          wr_ok;
  logic          wr_zero;

  assign in_ready = key_ready && (!out_valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign wr_ok    = bus.key_wr_en && (bus.key_wr_addr <= LAST_ADDR);
  assign wr_zero  = bus.key_wr_en && (bus.key_wr_addr == '0);

  assign bus.key_ready = key_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_round = out_round;
  assign bus.out_last  = out_last;

  // in_first forces round 0; otherwise the per-block counter selects the key
  always_comb begin
    er   = bus.in_first ? '0 : rnd;
    base = AW'({er, 2'b00});
    rk   = {key_mem[base], key_mem[base + AW'(1)],
            key_mem[base + AW'(2)], key_mem[base + AW'(3)]};
  end

  // Key store is not reset; reads above see the pre-write contents
  always_ff @(posedge clk) begin
    if (wr_ok) key_mem[bus.key_wr_addr] <= bus.key_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      rnd       <= '0;
    end else begin
      if (bus.key_wr_en && bus.key_wr_addr == LAST_ADDR) key_ready <= 1'b1;
      else if (wr_zero)                                  key_ready <= 1'b0;

      if (accept) begin
        out_data  <= bus.in_data ^ rk;
        out_round <= er;
        out_last  <= (er == LAST_RND);
        out_valid <= 1'b1;
        rnd       <= (er == LAST_RND) ? '0 : er + 4'd1;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end

      // Key reload abandons the block in flight
      if (wr_zero) rnd <= '0;
    end
  end

`ifdef ARK_PROTO_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      proto_err <= 1'b0;
    end else if (accept && ((bus.in_first && rnd != '0) ||
                            (!bus.in_first && rnd == '0))) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_add_round_key.sv
// Scoreboard bench for add_round_key using the FIPS-197 C.1 AES-128 key schedule.
module tb_add_round_key;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  add_round_key_if #(.AW(6)) bus ();

`ifdef ARK_PROTO_CHECK_EN
  logic proto_err;
  add_round_key #(.NR(10), .AW(6)) dut (.clk(clk), .rst(rst), .bus(bus), .proto_err(proto_err));
`else
  add_round_key #(.NR(10), .AW(6)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    logic [127:0] d;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [127:0] rk_tab [11];
  logic [31:0]  m_words [44];
  logic         m_key_ready;
  logic         m_out_valid;
  logic [3:0]   m_rnd;
  logic         m_perr;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] model_rk(input logic [3:0] r);
    int unsigned b;
    b = 4 * int'(r);
    return {m_words[b], m_words[b+1], m_words[b+2], m_words[b+3]};
  endfunction

  // Called just after a falling edge with inputs already driven
  task automatic tick();
    logic  exp_ir;
    logic  acc;
    logic  [3:0] er;
    exp_t  e;
    #1;
    exp_ir = m_key_ready && (!m_out_valid || bus.out_ready);
    check("in_ready",  128'(bus.in_ready),  128'(exp_ir));
    check("out_valid", 128'(bus.out_valid), 128'(m_out_valid));
    check("key_ready", 128'(bus.key_ready), 128'(m_key_ready));
`ifdef ARK_PROTO_CHECK_EN
    check("proto_err", 128'(proto_err), 128'(m_perr));
`endif
    if (m_out_valid) begin
      if (sb.size() == 0) begin
        check("sb_size", 128'(sb.size()), 128'(1));
      end else begin
        check("out_data",  bus.out_data,          sb[0].d);
        check("out_round", 128'(bus.out_round),   128'(sb[0].r));
        check("out_last",  128'(bus.out_last),    128'(sb[0].l));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    acc = bus.in_valid && exp_ir;
    if (acc) begin
      er  = bus.in_first ? 4'd0 : m_rnd;
      e.d = bus.in_data ^ model_rk(er);
      e.r = er;
      e.l = (er == 4'd10);
      sb.push_back(e);
      if ((bus.in_first && m_rnd != 0) || (!bus.in_first && m_rnd == 0)) m_perr = 1'b1;
      m_rnd = (er == 4'd10) ? 4'd0 : er + 4'd1;
    end
    if (bus.key_wr_en && bus.key_wr_addr < 6'd44) begin
      m_words[bus.key_wr_addr] = bus.key_wr_data;
      if (bus.key_wr_addr == 6'd43) m_key_ready = 1'b1;
      if (bus.key_wr_addr == 6'd0) begin
        m_key_ready = 1'b0;
        m_rnd       = 4'd0;
      end
    end
    if (acc)                m_out_valid = 1'b1;
    else if (bus.out_ready) m_out_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.key_wr_en = 1'b0;
  endtask

  task automatic send(input logic first, input logic [127:0] d);
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic load_keys();
    logic [127:0] rk;
    for (int i = 0; i < 44; i++) begin
      rk              = rk_tab[i/4];
      bus.key_wr_en   = 1'b1;
      bus.key_wr_addr = 6'(i);
      bus.key_wr_data = rk[127 - 32*(i%4) -: 32];
      tick();
    end
    bus.key_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data",  bus.out_data,        128'(0));
    check("rst_out_round", 128'(bus.out_round), 128'(0));
    check("rst_out_last",  128'(bus.out_last),  128'(0));
    check("rst_key_ready", 128'(bus.key_ready), 128'(0));
`ifdef ARK_PROTO_CHECK_EN
    check("rst_proto_err", 128'(proto_err), 128'(0));
`endif
    m_key_ready = 1'b0;
    m_out_valid = 1'b0;
    m_rnd       = 4'd0;
    m_perr      = 1'b0;
    sb.delete();
    rst = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_tab[1]  = 128'hd6aa74fdd2af72fadaaa78f1d6ac76fe;
    rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 0; i < 44; i++) m_words[i] = '0;
    bus.key_wr_addr = '0;
    bus.key_wr_data = '0;
    bus.in_first    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    idle();
    @(negedge clk);
    do_reset();
    @(negedge clk);

    load_keys();
    tick();

    // Write above the key range must not disturb key_ready
    bus.key_wr_en   = 1'b1;
    bus.key_wr_addr = 6'd63;
    bus.key_wr_data = $urandom;
    tick();
    idle();
    tick();

    send(1'b1, 128'h00112233445566778899aabbccddeeff);
    check("c1_round0_data",  bus.out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    check("c1_round0_round", 128'(bus.out_round), 128'(0));
    check("c1_round0_last",  128'(bus.out_last),  128'(0));
    send(1'b0, 128'h0);
    check("c1_round1_data",  bus.out_data, 128'hd6aa74fdd2af72fadaaa78f1d6ac76fe);
    check("c1_round1_round", 128'(bus.out_round), 128'(1));

    // New block while rnd==2: abandons the block, flags a protocol error
    for (int i = 0; i < 11; i++) send(i == 0, rnd128());
    check("full_last_round", 128'(bus.out_round), 128'(10));
    check("full_last_flag",  128'(bus.out_last),  128'(1));
`ifdef ARK_PROTO_CHECK_EN
    check("proto_mid_block", 128'(proto_err), 128'(1));
`endif
    send(1'b1, rnd128());
    check("wrap_round0", 128'(bus.out_round), 128'(0));
    for (int i = 0; i < 10; i++) send(1'b0, rnd128());
    send(1'b0, rnd128());
    check("counter_round0", 128'(bus.out_round), 128'(0));
    tick();

    bus.out_ready = 1'b0;
    send(1'b0, rnd128());
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_first = 1'b0;
      bus.in_data  = rnd128();
      tick();
    end
    idle();
    bus.out_ready = 1'b1;
    tick();
    tick();

    send(1'b1, rnd128());
    send(1'b0, rnd128());
    send(1'b0, rnd128());
    // Accept at round 3 coincides with the address-0 write
    bus.in_valid    = 1'b1;
    bus.in_first    = 1'b0;
    bus.in_data     = rnd128();
    bus.key_wr_en   = 1'b1;
    bus.key_wr_addr = 6'd0;
    bus.key_wr_data = 32'hdeadbeef;
    tick();
    bus.key_wr_en = 1'b0;
    tick();
    idle();
    tick();
    load_keys();
    tick();
    send(1'b0, rnd128());
    check("reload_round0", 128'(bus.out_round), 128'(0));

    bus.out_ready = 1'b0;
    send(1'b0, rnd128());
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("sb_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
